// File: rtl/trap_collector.sv
// Collects exception causes at IF/ID/EX/MEM, carries them down the pipeline with
// each instruction, and resolves one exception, interrupt or mret report at MEM.
module trap_collector #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BUSY_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_access_fault,
  input  logic        id_illegal,
  input  logic        id_ebreak,
  input  logic        id_ecall,
  input  logic        id_mret,
  input  logic        ex_ld_misaligned,
  input  logic        ex_st_misaligned,
  input  logic        l_access_fault_in,
  input  logic        s_access_fault_in,
  input  logic        stall_FD,
  input  logic        stall_DE,
  input  logic        stall_EM,
  input  logic        flush_FD,
  input  logic        flush_DE,
  input  logic        flush_EM,
  input  logic        trap_flush,
  input  logic        mstatus_mie,
  input  logic        ext_irq,
  output logic        illegal_inst,
  output logic        l_access_fault,
  output logic        s_access_fault,
  output logic        ecall_m,
  output logic        mret,
  output logic        interrupt,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc
);

  localparam int BW = (BUSY_CYCLES < 1) ? 1 : $clog2(BUSY_CYCLES + 1);

  typedef struct packed {
    logic        valid;
    logic        exc;
    logic [3:0]  code;
    logic        mret;
    logic [31:0] pc;
  } rec_t;

  localparam rec_t REC_RESET = '{valid: 1'b0, exc: 1'b0, code: 4'd0, mret: 1'b0, pc: RESET_PC};

  function automatic rec_t bubble(input rec_t r);
    rec_t b;
    b       = r;
    b.valid = 1'b0;
    b.exc   = 1'b0;
    b.mret  = 1'b0;
    return b;
  endfunction

  rec_t          d_q, e_q, m_q;
  rec_t          d_next, e_next, m_next;
  logic [BW-1:0] busy_q;
  logic          sync1_q, sync2_q, sync3_q, irq_pend_q;
  logic          irq_rise, rpt_irq, rpt_exc, rpt_accept;
  logic [3:0]    rpt_code;

  always_comb begin : stage_load
    // NOTE: every signal driven here gets a full default first, so no path can infer a latch.
    d_next = '{valid: if_valid, exc: if_access_fault, code: 4'd1, mret: 1'b0, pc: if_pc};

    // The oldest cause wins: later stages only annotate records that are still clean.
    e_next = d_q;
    if (!d_q.exc) begin
      if (id_illegal) begin
        e_next.exc  = 1'b1;
        e_next.code = 4'd2;
      end else if (id_ebreak) begin
        e_next.exc  = 1'b1;
        e_next.code = 4'd3;
      end else if (id_ecall) begin
        e_next.exc  = 1'b1;
        e_next.code = 4'd11;
      end else if (id_mret) begin
        e_next.mret = 1'b1;
      end
    end
    if (stall_FD) e_next = bubble(d_q);

    m_next = e_q;
    if (!e_q.exc) begin
      if (ex_ld_misaligned) begin
        m_next.exc  = 1'b1;
        m_next.code = 4'd4;
      end else if (ex_st_misaligned) begin
        m_next.exc  = 1'b1;
        m_next.code = 4'd6;
      end
    end
    if (stall_DE) m_next = bubble(e_q);
  end

  always_ff @(posedge clk or posedge rst) begin : stage_regs
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      d_q <= REC_RESET;
      e_q <= REC_RESET;
      m_q <= REC_RESET;
    end else begin
      if (trap_flush || flush_FD) d_q <= bubble(d_q);
      else if (!stall_FD)         d_q <= d_next;

      if (trap_flush || flush_DE) e_q <= bubble(e_q);
      else if (!stall_DE)         e_q <= e_next;

      if (trap_flush || flush_EM) m_q <= bubble(m_q);
      else if (!stall_EM)         m_q <= m_next;
    end
  end

  always_comb begin : resolve
    rpt_irq        = 1'b0;
    rpt_exc        = 1'b0;
    rpt_code       = 4'd0;
    illegal_inst   = 1'b0;
    l_access_fault = 1'b0;
    s_access_fault = 1'b0;
    ecall_m        = 1'b0;
    mret           = 1'b0;
    interrupt      = 1'b0;
    trap_cause     = 32'd0;
    trap_pc        = m_q.pc;

    if (m_q.valid && busy_q == '0) begin
      if (irq_pend_q && mstatus_mie) begin
        rpt_irq = 1'b1;
      end else if (m_q.exc) begin
        rpt_exc  = 1'b1;
        rpt_code = m_q.code;
      end else if (l_access_fault_in) begin
        rpt_exc  = 1'b1;
        rpt_code = 4'd5;
      end else if (s_access_fault_in) begin
        rpt_exc  = 1'b1;
        rpt_code = 4'd7;
      end else if (m_q.mret) begin
        mret = 1'b1;
      end
    end

    if (rpt_irq) begin
      interrupt  = 1'b1;
      trap_cause = 32'h8000_000B;
    end else if (rpt_exc) begin
      trap_cause = {28'd0, rpt_code};
      case (rpt_code)
        4'd2, 4'd3:       illegal_inst   = 1'b1;
        4'd11:            ecall_m        = 1'b1;
        4'd1, 4'd4, 4'd5: l_access_fault = 1'b1;
        4'd6, 4'd7:       s_access_fault = 1'b1;
        default:          ;
      endcase
    end
  end

  // A report is consumed only on a cycle where M advances; while M is held it stays visible.
  assign rpt_accept = (rpt_irq | rpt_exc) & ~stall_EM;
  assign irq_rise   = sync2_q & ~sync3_q;

  always_ff @(posedge clk or posedge rst) begin : irq_busy_regs
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      irq_pend_q <= 1'b0;
      busy_q     <= '0;
    end else begin
      sync1_q <= ext_irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;

      if (irq_rise)                  irq_pend_q <= 1'b1;
      else if (rpt_irq && rpt_accept) irq_pend_q <= 1'b0;

      if (rpt_accept)        busy_q <= BW'(BUSY_CYCLES);
      else if (busy_q != '0) busy_q <= busy_q - BW'(1);
    end
  end

endmodule

// File: tb/tb_trap_collector.sv
// Self-checking bench for trap_collector: directed scenarios plus a randomized
// run compared cycle by cycle against a stage-list reference model.
module tb_trap_collector;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          BUSY     = 2;

  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_ILL   = 6'b100000;
  localparam logic [5:0] S_LAF   = 6'b010000;
  localparam logic [5:0] S_SAF   = 6'b001000;
  localparam logic [5:0] S_ECALL = 6'b000100;
  localparam logic [5:0] S_MRET  = 6'b000010;
  localparam logic [5:0] S_IRQ   = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_access_fault;
  logic [31:0] if_pc;
  logic        id_illegal, id_ebreak, id_ecall, id_mret;
  logic        ex_ld_misaligned, ex_st_misaligned;
  logic        l_access_fault_in, s_access_fault_in;
  logic        stall_FD, stall_DE, stall_EM, flush_FD, flush_DE, flush_EM;
  logic        trap_flush, mstatus_mie, ext_irq;
  logic        illegal_inst, l_access_fault, s_access_fault, ecall_m, mret, interrupt;
  logic [31:0] trap_cause, trap_pc;

  int checks = 0;
  int errors = 0;

  trap_collector #(.RESET_PC(RESET_PC), .BUSY_CYCLES(BUSY)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_access_fault(if_access_fault),
    .id_illegal(id_illegal), .id_ebreak(id_ebreak), .id_ecall(id_ecall), .id_mret(id_mret),
    .ex_ld_misaligned(ex_ld_misaligned), .ex_st_misaligned(ex_st_misaligned),
    .l_access_fault_in(l_access_fault_in), .s_access_fault_in(s_access_fault_in),
    .stall_FD(stall_FD), .stall_DE(stall_DE), .stall_EM(stall_EM),
    .flush_FD(flush_FD), .flush_DE(flush_DE), .flush_EM(flush_EM),
    .trap_flush(trap_flush), .mstatus_mie(mstatus_mie), .ext_irq(ext_irq),
    .illegal_inst(illegal_inst), .l_access_fault(l_access_fault), .s_access_fault(s_access_fault),
    .ecall_m(ecall_m), .mret(mret), .interrupt(interrupt),
    .trap_cause(trap_cause), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] strobes();
    return {illegal_inst, l_access_fault, s_access_fault, ecall_m, mret, interrupt};
  endfunction

  function automatic logic [69:0] obs();
    return {strobes(), trap_cause, trap_pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_valid = 0; if_pc = 32'd0; if_access_fault = 0;
    id_illegal = 0; id_ebreak = 0; id_ecall = 0; id_mret = 0;
    ex_ld_misaligned = 0; ex_st_misaligned = 0;
    l_access_fault_in = 0; s_access_fault_in = 0;
    stall_FD = 0; stall_DE = 0; stall_EM = 0;
    flush_FD = 0; flush_DE = 0; flush_EM = 0;
    trap_flush = 0; mstatus_mie = 0; ext_irq = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    bit          e;
    int          code;
    bit          m;
    logic [31:0] pc;
  } mrec_t;

  mrec_t st[3];
  bit    irq_hist[$];
  bit    m_pend;
  int    m_busy;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) st[k] = '{v: 0, e: 0, code: 0, m: 0, pc: RESET_PC};
    irq_hist = {1'b0, 1'b0, 1'b0};
    m_pend   = 0;
    m_busy   = 0;
  endtask

  // kind: 0 none, 1 interrupt, 2 exception, 3 mret
  task automatic model_resolve(output int kind, output int code);
    bit f[3];
    int c[3];
    kind = 0;
    code = 0;
    if (!st[2].v || m_busy != 0) return;
    if (m_pend && mstatus_mie) begin
      kind = 1;
      return;
    end
    f = '{st[2].e, l_access_fault_in, s_access_fault_in};
    c = '{st[2].code, 5, 7};
    for (int i = 0; i < 3; i++)
      if (f[i]) begin
        kind = 2;
        code = c[i];
        return;
      end
    if (st[2].m) kind = 3;
  endtask

  function automatic logic [5:0] strobe_of(input int kind, input int code);
    if (kind == 1) return S_IRQ;
    if (kind == 3) return S_MRET;
    if (kind != 2) return S_NONE;
    if (code == 2 || code == 3) return S_ILL;
    if (code == 11) return S_ECALL;
    if (code == 1 || code == 4 || code == 5) return S_LAF;
    if (code == 6 || code == 7) return S_SAF;
    return S_NONE;
  endfunction

  task automatic model_step();
    int    kind, code;
    bit    accepted, rise;
    mrec_t old[3];
    mrec_t src;
    bit    clr[3], hold[3], f[3];
    int    c[3];
    int    n;
    model_resolve(kind, code);
    accepted = (kind == 1 || kind == 2) && !stall_EM;
    irq_hist.push_front(ext_irq);
    while (irq_hist.size() > 4) void'(irq_hist.pop_back());
    rise = irq_hist[2] && !irq_hist[3];
    if (rise) m_pend = 1;
    else if (kind == 1 && accepted) m_pend = 0;
    m_busy = accepted ? BUSY : (m_busy > 0 ? m_busy - 1 : 0);

    old  = st;
    clr  = '{trap_flush || flush_FD, trap_flush || flush_DE, trap_flush || flush_EM};
    hold = '{stall_FD, stall_DE, stall_EM};
    for (int k = 0; k < 3; k++) begin
      if (clr[k]) begin
        st[k].v = 0; st[k].e = 0; st[k].m = 0;
      end else if (!hold[k]) begin
        if (k == 0) src = '{v: if_valid, e: if_access_fault, code: 1, m: 0, pc: if_pc};
        else        src = old[k-1];
        n = 0;
        if (k == 1) begin
          f = '{id_illegal, id_ebreak, id_ecall}; c = '{2, 3, 11}; n = 3;
        end else if (k == 2) begin
          f = '{ex_ld_misaligned, ex_st_misaligned, 1'b0}; c = '{4, 6, 0}; n = 2;
        end
        if (!src.e && n > 0) begin
          for (int i = 0; i < n; i++)
            if (f[i] && !src.e) begin
              src.e = 1; src.code = c[i];
            end
          if (k == 1 && !src.e && id_mret) src.m = 1;
        end
        if (k > 0 && hold[k-1]) begin
          src.v = 0; src.e = 0; src.m = 0;
        end
        st[k] = src;
      end
    end
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if (obs() !== {S_NONE, 32'd0, RESET_PC}) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", obs(), {S_NONE, 32'd0, RESET_PC});
    end
    tick();
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (obs() !== {S_NONE, 32'd0, RESET_PC}) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs(), {S_NONE, 32'd0, RESET_PC});
    end
  endtask

  task automatic test_if_fault();
    do_reset();
    if_valid = 1; if_pc = 32'h100; if_access_fault = 1;
    tick();
    if_valid = 0; if_access_fault = 0;
    for (int i = 1; i < 3; i++) begin
      #1;
      checks++;
      if (strobes() !== S_NONE) begin
        errors++;
        $display("FAIL if_fault_early cycle %0d: got %b want %b", i, strobes(), S_NONE);
      end
      tick();
    end
    #1;
    checks++;
    if (obs() !== {S_LAF, 32'd1, 32'h100}) begin
      errors++;
      $display("FAIL if_fault_report: got %h want %h", obs(), {S_LAF, 32'd1, 32'h100});
    end
  endtask

  task automatic test_illegal_ecall();
    do_reset();
    if_valid = 1; if_pc = 32'h204;
    tick();
    if_valid = 0; id_illegal = 1; id_ecall = 1;
    tick();
    id_illegal = 0; id_ecall = 0;
    tick();
    #1;
    checks++;
    if (obs() !== {S_ILL, 32'd2, 32'h204}) begin
      errors++;
      $display("FAIL illegal_priority: got %h want %h", obs(), {S_ILL, 32'd2, 32'h204});
    end
    trap_flush = 1;
    tick();
    trap_flush = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (strobes() !== S_NONE) begin
        errors++;
        $display("FAIL after_trap_flush cycle %0d: got %b want %b", i, strobes(), S_NONE);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_valid = 1; if_access_fault = 1; if_pc = 32'h10;
    tick();
    if_pc = 32'h14;
    tick();
    if_valid = 0; if_access_fault = 0;
    tick();
    #1;
    checks++;
    if (obs() !== {S_LAF, 32'd1, 32'h10}) begin
      errors++;
      $display("FAIL b2b_first: got %h want %h", obs(), {S_LAF, 32'd1, 32'h10});
    end
    tick();
    stall_EM = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (strobes() !== S_NONE) begin
        errors++;
        $display("FAIL b2b_busy cycle %0d: got %b want %b", i, strobes(), S_NONE);
      end
      tick();
    end
    #1;
    checks++;
    if (obs() !== {S_LAF, 32'd1, 32'h14}) begin
      errors++;
      $display("FAIL b2b_second: got %h want %h", obs(), {S_LAF, 32'd1, 32'h14});
    end
    stall_EM = 0; trap_flush = 1;
    tick();
    trap_flush = 0;
  endtask

  task automatic test_misaligned_priority();
    do_reset();
    if_valid = 1; if_pc = 32'h40;
    tick();
    if_valid = 0;
    tick();
    ex_ld_misaligned = 1;
    tick();
    ex_ld_misaligned = 0; l_access_fault_in = 1;
    #1;
    checks++;
    if (obs() !== {S_LAF, 32'd4, 32'h40}) begin
      errors++;
      $display("FAIL misaligned_over_mem: got %h want %h", obs(), {S_LAF, 32'd4, 32'h40});
    end
    l_access_fault_in = 0;
  endtask

  task automatic test_interrupt();
    do_reset();
    mstatus_mie = 1; if_valid = 1; if_pc = 32'h300; ext_irq = 1;
    tick();
    tick();
    #1;
    checks++;
    if (strobes() !== S_NONE) begin
      errors++;
      $display("FAIL irq_early: got %b want %b", strobes(), S_NONE);
    end
    tick();
    #1;
    checks++;
    if (obs() !== {S_IRQ, 32'h8000_000B, 32'h300}) begin
      errors++;
      $display("FAIL irq_taken: got %h want %h", obs(), {S_IRQ, 32'h8000_000B, 32'h300});
    end
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (strobes() !== S_NONE) begin
      errors++;
      $display("FAIL irq_pend_cleared: got %b want %b", strobes(), S_NONE);
    end
    mstatus_mie = 0; ext_irq = 0;
    repeat (3) tick();
    ext_irq = 1;
    repeat (5) tick();
    #1;
    checks++;
    if (strobes() !== S_NONE) begin
      errors++;
      $display("FAIL irq_masked: got %b want %b", strobes(), S_NONE);
    end
    mstatus_mie = 1;
    #1;
    checks++;
    if (obs() !== {S_IRQ, 32'h8000_000B, 32'h300}) begin
      errors++;
      $display("FAIL irq_still_pending: got %h want %h", obs(), {S_IRQ, 32'h8000_000B, 32'h300});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_stall_hold();
    do_reset();
    if_valid = 1; if_pc = 32'h500;
    tick();
    if_valid = 0; id_ecall = 1;
    tick();
    id_ecall = 0;
    tick();
    stall_FD = 1; stall_DE = 1; stall_EM = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs() !== {S_ECALL, 32'd11, 32'h500}) begin
        errors++;
        $display("FAIL ecall_held cycle %0d: got %h want %h", i, obs(), {S_ECALL, 32'd11, 32'h500});
      end
      tick();
    end
    stall_FD = 0; stall_DE = 0; stall_EM = 0; trap_flush = 1;
    tick();
    trap_flush = 0;
    tick();
    if_valid = 1; if_pc = 32'h520;
    tick();
    if_valid = 0; id_illegal = 1;
    tick();
    id_illegal = 0; stall_DE = 1; flush_DE = 1;
    tick();
    stall_DE = 0; flush_DE = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (strobes() !== S_NONE) begin
        errors++;
        $display("FAIL flush_beats_stall cycle %0d: got %b want %b", i, strobes(), S_NONE);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_trap();
    do_reset();
    ext_irq = 1; if_valid = 1; if_pc = 32'h600;
    repeat (4) tick();
    if_access_fault = 1;
    tick();
    if_access_fault = 0;
    tick();
    tick();
    #1;
    checks++;
    if (obs() !== {S_LAF, 32'd1, 32'h600}) begin
      errors++;
      $display("FAIL pre_reset_report: got %h want %h", obs(), {S_LAF, 32'd1, 32'h600});
    end
    tick();
    #2;
    rst = 1; ext_irq = 0;
    #1;
    checks++;
    if (obs() !== {S_NONE, 32'd0, RESET_PC}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs(), {S_NONE, 32'd0, RESET_PC});
    end
    tick();
    rst = 0; mstatus_mie = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (strobes() !== S_NONE) begin
        errors++;
        $display("FAIL post_reset_quiet cycle %0d: got %b want %b", i, strobes(), S_NONE);
      end
      tick();
    end
    if_pc = 32'h700; if_access_fault = 1;
    tick();
    if_pc = 32'h704; if_access_fault = 0;
    tick();
    tick();
    #1;
    checks++;
    if (obs() !== {S_LAF, 32'd1, 32'h700}) begin
      errors++;
      $display("FAIL post_reset_new_cause: got %h want %h", obs(), {S_LAF, 32'd1, 32'h700});
    end
  endtask

  task automatic test_random();
    int          kind, code;
    logic [5:0]  exp_s;
    logic [31:0] exp_c;
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if_valid          = ($urandom_range(0, 99) < 70);
      if_pc             = $urandom() & 32'hFFFF_FFFC;
      if_access_fault   = ($urandom_range(0, 99) < 8);
      id_illegal        = ($urandom_range(0, 99) < 8);
      id_ebreak         = ($urandom_range(0, 99) < 8);
      id_ecall          = ($urandom_range(0, 99) < 8);
      id_mret           = ($urandom_range(0, 99) < 10);
      ex_ld_misaligned  = ($urandom_range(0, 99) < 8);
      ex_st_misaligned  = ($urandom_range(0, 99) < 8);
      l_access_fault_in = ($urandom_range(0, 99) < 6);
      s_access_fault_in = ($urandom_range(0, 99) < 6);
      stall_FD          = ($urandom_range(0, 99) < 15);
      stall_DE          = ($urandom_range(0, 99) < 15);
      stall_EM          = ($urandom_range(0, 99) < 15);
      flush_FD          = ($urandom_range(0, 99) < 5);
      flush_DE          = ($urandom_range(0, 99) < 5);
      flush_EM          = ($urandom_range(0, 99) < 5);
      trap_flush        = ($urandom_range(0, 99) < 5);
      mstatus_mie       = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 19) == 0) ext_irq = ~ext_irq;
      #1;
      model_resolve(kind, code);
      exp_s = strobe_of(kind, code);
      exp_c = (kind == 1) ? 32'h8000_000B : (kind == 2) ? 32'(code) : 32'd0;
      checks++;
      if (kind != 0) begin
        if (obs() !== {exp_s, exp_c, st[2].pc}) begin
          errors++;
          $display("FAIL random_report cycle %0d: got %h want %h", n, obs(), {exp_s, exp_c, st[2].pc});
        end
      end else if ({strobes(), trap_cause} !== {S_NONE, 32'd0}) begin
        errors++;
        $display("FAIL random_quiet cycle %0d: got %h want %h", n, {strobes(), trap_cause}, {S_NONE, 32'd0});
      end
      @(posedge clk);
      model_step();
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #1;
    test_reset();
    test_if_fault();
    test_illegal_ecall();
    test_back_to_back();
    test_misaligned_priority();
    test_interrupt();
    test_stall_hold();
    test_reset_mid_trap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
